// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared sprite geometry and BCD score types
package score_pkg;

  localparam int SPRITE_W      = 32;
  localparam int SPRITE_H      = 32;
  localparam int SPRITE_ADDR_W = 19;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    bcd_digit_t hundreds;
    bcd_digit_t tens;
    bcd_digit_t units;
  } score_t;

endpackage

// File: rtl/score_digit_fetch_if.sv
// rtl/score_digit_fetch_if.sv - score control, pixel position and ROM fetch bundle
interface score_digit_fetch_if;
  import score_pkg::*;

  logic                     score_inc;
  logic                     score_clr;
  logic [9:0]               DrawX;
  logic [9:0]               DrawY;
  logic [SPRITE_ADDR_W-1:0] read_address;
  logic [3:0]               digit_sel;
  logic                     sprite_on;
  logic [11:0]              score_bcd;

  // Drives score pulses and pixel position, consumes the fetch results
  modport master (
    output score_inc, score_clr, DrawX, DrawY,
    input  read_address, digit_sel, sprite_on, score_bcd
  );

  // The fetch block itself
  modport slave (
    input  score_inc, score_clr, DrawX, DrawY,
    output read_address, digit_sel, sprite_on, score_bcd
  );

endinterface

// File: rtl/bcd_sat_counter.sv
// rtl/bcd_sat_counter.sv - 3-digit BCD counter, saturating at 999, clear wins over increment
module bcd_sat_counter
  import score_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   inc,
  input  logic   clr,
  output score_t score
);

  score_t score_q;
  score_t score_d;
  logic   at_max;

  assign at_max = (score_q.hundreds == 4'd9) && (score_q.tens == 4'd9) && (score_q.units == 4'd9);

  // Next score: clear first, otherwise ripple-carry increment unless already at 999
  always_comb begin
    score_d = score_q;
    if (clr) begin
      score_d = '0;
    end else if (inc && !at_max) begin
      if (score_q.units == 4'd9) begin
        score_d.units = 4'd0;
        if (score_q.tens == 4'd9) begin
          score_d.tens     = 4'd0;
          score_d.hundreds = score_q.hundreds + 4'd1;
        end else begin
          score_d.tens = score_q.tens + 4'd1;
        end
      end else begin
        score_d.units = score_q.units + 4'd1;
      end
    end
  end

  // Score register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_q <= '0;
    end else begin
      score_q <= score_d;
    end
  end

  assign score = score_q;

endmodule

// File: rtl/score_digit_fetch.sv
// rtl/score_digit_fetch.sv - maps pixel position in the score box to digit ROM address and select
module score_digit_fetch
  import score_pkg::*;
#(
  parameter logic [9:0] X_ORIGIN      = 10'd544,
  parameter logic [9:0] Y_ORIGIN      = 10'd16,
  parameter int         NUM_DIGITS    = 3,
  parameter bit         BLANK_LEADING = 1'b1
) (
  input  logic                Clk,
  input  logic                Reset_n,
  score_digit_fetch_if.slave  bus
);

  localparam int BOX_W = NUM_DIGITS * SPRITE_W;

  score_t score_live;

  // Frame snapshot, pipeline stage 1 and stage 2 registers
  score_t                   snap_q,      snap_d;
  logic [SPRITE_ADDR_W-1:0] addr_q,      addr_d;
  logic                     v1_q,        v1_d;
  bcd_digit_t               d1_q,        d1_d;
  logic                     sprite_on_q, sprite_on_d;
  bcd_digit_t               digit_sel_q, digit_sel_d;

  // Stage 0 hit-test signals
  logic [10:0] x_ext, y_ext, x_lo, x_hi, y_lo, y_hi;
  logic        in_box;
  logic [6:0]  lx;
  logic [4:0]  ly;
  logic [1:0]  slot;
  bcd_digit_t  slot_digit;
  logic        slot_blank;

  bcd_sat_counter u_counter (
    .clk   (Clk),
    .rst_n (Reset_n),
    .inc   (bus.score_inc),
    .clr   (bus.score_clr),
    .score (score_live)
  );

  // Box bounds are compared one bit wider so X_ORIGIN+width cannot wrap
  assign x_ext = {1'b0, bus.DrawX};
  assign y_ext = {1'b0, bus.DrawY};
  assign x_lo  = {1'b0, X_ORIGIN};
  assign y_lo  = {1'b0, Y_ORIGIN};
  assign x_hi  = x_lo + 11'(BOX_W);
  assign y_hi  = y_lo + 11'(SPRITE_H);

  assign in_box = (x_ext >= x_lo) && (x_ext < x_hi) && (y_ext >= y_lo) && (y_ext < y_hi);

  // Local offsets wrap outside the box; they are only meaningful when in_box is set
  assign lx   = 7'(bus.DrawX - X_ORIGIN);
  assign ly   = 5'(bus.DrawY - Y_ORIGIN);
  assign slot = lx[6:5];

  // Pick the snapshot digit for the current slot and decide leading-zero blanking
  always_comb begin
    slot_digit = snap_q.units;
    slot_blank = 1'b0;
    case (slot)
      2'd0: begin
        slot_digit = snap_q.hundreds;
        slot_blank = BLANK_LEADING && (snap_q.hundreds == 4'd0);
      end
      2'd1: begin
        slot_digit = snap_q.tens;
        slot_blank = BLANK_LEADING && (snap_q.hundreds == 4'd0) && (snap_q.tens == 4'd0);
      end
      default: begin
        slot_digit = snap_q.units;
        slot_blank = 1'b0;
      end
    endcase
  end

  // Next-state for snapshot and both pipeline stages
  always_comb begin
    snap_d      = snap_q;
    addr_d      = '0;
    v1_d        = 1'b0;
    d1_d        = '0;
    sprite_on_d = v1_q;
    digit_sel_d = d1_q;
    // Latch the live score at the top-left pixel so a frame never shows two values
    if ((bus.DrawX == 10'd0) && (bus.DrawY == 10'd0)) begin
      snap_d = score_live;
    end
    if (in_box) begin
      addr_d = SPRITE_ADDR_W'({ly, lx[4:0]});
      v1_d   = !slot_blank;
      d1_d   = slot_digit;
    end
  end

  // Pipeline registers; stage 2 lines up with the ROM's registered data_Out
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      snap_q      <= '0;
      addr_q      <= '0;
      v1_q        <= 1'b0;
      d1_q        <= '0;
      sprite_on_q <= 1'b0;
      digit_sel_q <= '0;
    end else begin
      snap_q      <= snap_d;
      addr_q      <= addr_d;
      v1_q        <= v1_d;
      d1_q        <= d1_d;
      sprite_on_q <= sprite_on_d;
      digit_sel_q <= digit_sel_d;
    end
  end

  assign bus.read_address = addr_q;
  assign bus.sprite_on    = sprite_on_q;
  assign bus.digit_sel    = digit_sel_q;
  assign bus.score_bcd    = score_live;

endmodule

// File: tb/tb_score_digit_fetch.sv
// tb/tb_score_digit_fetch.sv - self-checking bench for score_digit_fetch
module tb_score_digit_fetch;

  localparam int X0 = 544;
  localparam int Y0 = 16;

  logic Clk     = 1'b0;
  logic Reset_n = 1'b0;

  always #5 Clk = ~Clk;

  score_digit_fetch_if bus_a ();
  score_digit_fetch_if bus_b ();

  assign bus_b.score_inc = bus_a.score_inc;
  assign bus_b.score_clr = bus_a.score_clr;
  assign bus_b.DrawX     = bus_a.DrawX;
  assign bus_b.DrawY     = bus_a.DrawY;

  score_digit_fetch #(
    .X_ORIGIN(10'd544), .Y_ORIGIN(10'd16), .NUM_DIGITS(3), .BLANK_LEADING(1'b1)
  ) dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus_a.slave)
  );

  score_digit_fetch #(
    .X_ORIGIN(10'd544), .Y_ORIGIN(10'd16), .NUM_DIGITS(3), .BLANK_LEADING(1'b0)
  ) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus_b.slave)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x;
    int y;
    int addr;
    int on_a;
    int dig_a;
    int on_b;
    int dig_b;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_px(input int x, input int y);
    bus_a.DrawX = 10'(x);
    bus_a.DrawY = 10'(y);
  endtask

  function automatic int bcd(input int s);
    return ((s / 100) << 8) | (((s / 10) % 10) << 4) | (s % 10);
  endfunction

  // Reference: what a pixel should show given the displayed score
  function automatic void model_pix(input int disp, input int x, input int y, input int bl,
                                    output int on, output int dig, output int addr);
    int col;
    on = 0; dig = 0; addr = 0;
    if (x >= X0 && x < X0 + 96 && y >= Y0 && y < Y0 + 32) begin
      col  = x - X0;
      addr = (y - Y0) * 32 + (col % 32);
      case (col / 32)
        0: begin dig = disp / 100;        on = (bl != 0 && disp < 100) ? 0 : 1; end
        1: begin dig = (disp / 10) % 10;  on = (bl != 0 && disp < 10)  ? 0 : 1; end
        default: begin dig = disp % 10;   on = 1; end
      endcase
    end
  endfunction

  // Clear, count up to n, then take a frame snapshot
  task automatic load_score(input int n);
    set_px(700, 500);
    bus_a.score_clr = 1'b1;
    tick();
    bus_a.score_clr = 1'b0;
    bus_a.score_inc = 1'b1;
    repeat (n) tick();
    bus_a.score_inc = 1'b0;
    set_px(0, 0);
    tick();
    set_px(700, 500);
  endtask

  // Hold a pixel for two edges and compare both DUTs against the model
  task automatic show(input string tag, input int x, input int y, input int disp);
    int on, dig, addr;
    set_px(x, y);
    model_pix(disp, x, y, 1, on, dig, addr);
    tick();
    check({tag, "_addr"}, int'(bus_a.read_address), addr);
    tick();
    check({tag, "_on_a"}, int'(bus_a.sprite_on), on);
    if (on != 0) check({tag, "_dig_a"}, int'(bus_a.digit_sel), dig);
    model_pix(disp, x, y, 0, on, dig, addr);
    check({tag, "_on_b"}, int'(bus_b.sprite_on), on);
    if (on != 0) check({tag, "_dig_b"}, int'(bus_b.digit_sel), dig);
  endtask

  initial begin
    int m_score, m_snap, a_v1, a_d1, b_v1, b_d1;
    int e_on_a, e_dig_a, e_on_b, e_dig_b, e_addr, tmp, x, y, inc, clr;

    bus_a.score_inc = 1'b0;
    bus_a.score_clr = 1'b0;
    set_px(700, 500);

    #2;
    check("rst_score", int'(bus_a.score_bcd), 0);
    check("rst_addr",  int'(bus_a.read_address), 0);
    check("rst_on",    int'(bus_a.sprite_on), 0);
    check("rst_dig",   int'(bus_a.digit_sel), 0);
    @(negedge Clk);
    Reset_n = 1'b1;

    // Address, latency and box-edge vectors with snapshot 123
    tbl[0] = '{581, 20, 133,  1, 2, 1, 2};
    tbl[1] = '{543, 20, 0,    0, 0, 0, 0};
    tbl[2] = '{640, 20, 0,    0, 0, 0, 0};
    tbl[3] = '{600, 48, 0,    0, 0, 0, 0};
    tbl[4] = '{639, 47, 1023, 1, 3, 1, 3};
    tbl[5] = '{544, 16, 0,    1, 1, 1, 1};
    tbl[6] = '{575, 16, 31,   1, 1, 1, 1};
    tbl[7] = '{576, 16, 0,    1, 2, 1, 2};
    tbl[8] = '{608, 17, 32,   1, 3, 1, 3};
    tbl[9] = '{544, 15, 0,    0, 0, 0, 0};

    load_score(123);
    for (int i = 0; i < 10; i++) begin
      set_px(tbl[i].x, tbl[i].y);
      tick();
      check($sformatf("vec%0d_addr1", i), int'(bus_a.read_address), tbl[i].addr);
      check($sformatf("vec%0d_on1", i), int'(bus_a.sprite_on), 0);
      tick();
      check($sformatf("vec%0d_on_a", i), int'(bus_a.sprite_on), tbl[i].on_a);
      if (tbl[i].on_a != 0) check($sformatf("vec%0d_dig_a", i), int'(bus_a.digit_sel), tbl[i].dig_a);
      check($sformatf("vec%0d_on_b", i), int'(bus_b.sprite_on), tbl[i].on_b);
      if (tbl[i].on_b != 0) check($sformatf("vec%0d_dig_b", i), int'(bus_b.digit_sel), tbl[i].dig_b);
      set_px(700, 500);
      tick();
      tick();
    end

    // Asynchronous reset mid-frame with 042 on screen
    load_score(42);
    set_px(X0 + 40, 20);
    tick();
    tick();
    check("pre_rst_on",  int'(bus_a.sprite_on), 1);
    check("pre_rst_dig", int'(bus_a.digit_sel), 4);
    check("pre_rst_score", int'(bus_a.score_bcd), 'h042);
    @(negedge Clk);
    #1 Reset_n = 1'b0;
    #1;
    check("async_rst_score", int'(bus_a.score_bcd), 0);
    check("async_rst_on",    int'(bus_a.sprite_on), 0);
    check("async_rst_addr",  int'(bus_a.read_address), 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    set_px(700, 500);

    // Count 1000 pulses: ripples and saturation at 999
    bus_a.score_inc = 1'b1;
    for (int i = 1; i <= 1000; i++) begin
      tick();
      check($sformatf("count%0d", i), int'(bus_a.score_bcd), bcd(i > 999 ? 999 : i));
    end
    bus_a.score_inc = 1'b0;

    // Clear beats increment
    load_score(500);
    check("load500", int'(bus_a.score_bcd), 'h500);
    bus_a.score_inc = 1'b1;
    bus_a.score_clr = 1'b1;
    tick();
    bus_a.score_inc = 1'b0;
    bus_a.score_clr = 1'b0;
    check("clr_over_inc", int'(bus_a.score_bcd), 0);

    // Leading-zero blanking across a full row with 007
    load_score(7);
    for (int px = X0; px < X0 + 96; px++) show($sformatf("row007_x%0d", px), px, 20, 7);

    // Snapshot timing around 099 -> 100
    load_score(99);
    show("snap99_tens", X0 + 40, 20, 99);
    show("snap99_hund", X0 + 6, 20, 99);
    set_px(300, 200);
    bus_a.score_inc = 1'b1;
    tick();
    bus_a.score_inc = 1'b0;
    check("midframe_score", int'(bus_a.score_bcd), 'h100);
    show("hold99_hund", X0 + 6, 20, 99);
    show("hold99_tens", X0 + 40, 20, 99);
    set_px(0, 0);
    bus_a.score_inc = 1'b1;
    tick();
    bus_a.score_inc = 1'b0;
    check("frame_score", int'(bus_a.score_bcd), 'h101);
    show("new100_hund", X0 + 6, 20, 100);
    show("new100_tens", X0 + 40, 20, 100);
    show("new100_units", X0 + 70, 20, 100);

    // Randomized run against the reference model
    set_px(700, 500);
    Reset_n = 1'b0;
    #2;
    @(negedge Clk);
    Reset_n = 1'b1;
    m_score = 0; m_snap = 0;
    a_v1 = 0; a_d1 = 0; b_v1 = 0; b_d1 = 0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        x = 0; y = 0;
      end else begin
        x = $urandom_range(530, 650);
        y = $urandom_range(10, 55);
      end
      inc = ($urandom_range(0, 3) != 0) ? 1 : 0;
      clr = ($urandom_range(0, 399) == 0) ? 1 : 0;
      set_px(x, y);
      bus_a.score_inc = inc[0];
      bus_a.score_clr = clr[0];
      e_on_a = a_v1; e_dig_a = a_d1; e_on_b = b_v1; e_dig_b = b_d1;
      model_pix(m_snap, x, y, 1, a_v1, a_d1, e_addr);
      model_pix(m_snap, x, y, 0, b_v1, b_d1, tmp);
      if (x == 0 && y == 0) m_snap = m_score;
      if (clr != 0) m_score = 0;
      else if (inc != 0 && m_score < 999) m_score = m_score + 1;
      tick();
      check("rnd_score", int'(bus_a.score_bcd), bcd(m_score));
      check("rnd_addr", int'(bus_a.read_address), e_addr);
      check("rnd_on_a", int'(bus_a.sprite_on), e_on_a);
      if (e_on_a != 0) check("rnd_dig_a", int'(bus_a.digit_sel), e_dig_a);
      check("rnd_on_b", int'(bus_b.sprite_on), e_on_b);
      if (e_on_b != 0) check("rnd_dig_b", int'(bus_b.digit_sel), e_dig_b);
    end
    bus_a.score_inc = 1'b0;
    bus_a.score_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
